// File: rtl/fp16_acc_seq.sv
// fp16_acc_seq
//   Streaming fp16 sum-reduction sequencer wrapped around an external,
//   combinational fp16 adder (instantiated by the parent). This block holds
//   only the accumulator, packet counter and handshake state; it performs no
//   arithmetic of its own and never alters the adder result.
//
// Ports
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_valid/o_ready       operand input handshake
//   i_data, i_last        fp16 operand, end-of-packet marker
//   o_add_a, o_add_b      adder operands (accumulator, i_data pass-through)
//   i_add_res             adder result
//   o_valid/i_ready       packet-total output handshake
//   o_sum                 fp16 packet total (held after handshake)
//   o_count               elements accepted in current/finished packet (saturating)
//   o_ovf                 sticky: packet longer than 2^CNT_W-1 elements
module fp16_acc_seq #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_data,
  input  logic             i_last,
  output logic [15:0]      o_add_a,
  output logic [15:0]      o_add_b,
  input  logic [15:0]      i_add_res,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [15:0]      o_sum,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_OUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [15:0] acc;

  assign o_ready = (state != ST_OUT) & ~i_rst;
  assign o_valid = (state == ST_OUT);
  assign o_add_a = acc;
  assign o_add_b = i_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      o_sum   <= '0;
      o_count <= '0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (i_valid) begin
            acc <= i_add_res;
            if (o_count != CNT_MAX) begin
              o_count <= o_count + 1'b1;
            end else begin
              o_ovf <= 1'b1;
            end
            if (i_last) begin
              state <= ST_OUT;
              o_sum <= i_add_res;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_OUT: begin
          // The release cycle accepts no beat: o_ready is low throughout OUT.
          if (i_ready) begin
            state   <= ST_IDLE;
            acc     <= '0;
            o_count <= '0;
            o_ovf   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_acc_seq.sv
// tb_fp16_acc_seq
//   Drives two instances (CNT_W=8 and CNT_W=2) with identical stimulus and a
//   behavioural fp16 adder, and compares every cycle against a packet-level
//   reference model (running real-valued fp16 sum, element count, held total).
module tb_fp16_acc_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        last = 1'b0;
  logic        rdy = 1'b0;

  logic        ready8, valid8, ovf8;
  logic [15:0] add_a8, add_b8, res8, sum8;
  logic [7:0]  count8;

  logic        ready2, valid2, ovf2;
  logic [15:0] add_a2, add_b2, res2, sum2;
  logic [1:0]  count2;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [15:0] m_acc = '0;
  logic [15:0] m_last_sum = '0;
  int          m_len = 0;
  bit          m_holding = 1'b0;

  always #5 clk = ~clk;

  fp16_acc_seq #(.CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready8),
    .i_data(data), .i_last(last), .o_add_a(add_a8), .o_add_b(add_b8),
    .i_add_res(res8), .o_valid(valid8), .i_ready(rdy), .o_sum(sum8),
    .o_count(count8), .o_ovf(ovf8)
  );

  fp16_acc_seq #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready2),
    .i_data(data), .i_last(last), .o_add_a(add_a2), .o_add_b(add_b2),
    .i_add_res(res2), .o_valid(valid2), .i_ready(rdy), .o_sum(sum2),
    .o_count(count2), .o_ovf(ovf2)
  );

  // fp16 value as a real, subnormals read as zero.
  function automatic real fp16_val(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    v = (1024.0 + real'(h[9:0])) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  // Behavioural fp16 adder: RNE, DAZ/FTZ, canonical NaN 7C77, +Inf + -Inf = +0.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    bit   a_inf, b_inf, sgn;
    real  s, mag, f, rem;
    int   e, i;
    logic [4:0] ef;
    logic [9:0] mf;
    if ((a[14:10] == 5'h1f && a[9:0] != 0) || (b[14:10] == 5'h1f && b[9:0] != 0))
      return 16'h7C77;
    a_inf = (a[14:0] == 15'h7C00);
    b_inf = (b[14:0] == 15'h7C00);
    if (a_inf && b_inf && (a[15] != b[15])) return 16'h0000;
    if (a_inf) return a;
    if (b_inf) return b;
    s = fp16_val(a) + fp16_val(b);
    if (s == 0.0) return 16'h0000;
    sgn = (s < 0.0);
    mag = sgn ? -s : s;
    e = 15;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0) begin mag = mag * 2.0; e--; end
    f = mag * 1024.0;
    i = $rtoi(f);
    rem = f - real'(i);
    if (rem > 0.5 || (rem == 0.5 && (i % 2) == 1)) i++;
    if (i == 2048) begin i = 1024; e++; end
    if (e >= 31) return {sgn, 15'h7C00};
    if (e <= 0) return 16'h0000;
    ef = 5'(e);
    mf = 10'(i - 1024);
    return {sgn, ef, mf};
  endfunction

  always_comb res8 = fp16_add(add_a8, add_b8);
  always_comb res2 = fp16_add(add_a2, add_b2);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string pfx, input int cmax, input logic rdy_o,
                           input logic vld_o, input logic [15:0] sum_o,
                           input logic [31:0] cnt_o, input logic ovf_o,
                           input logic [15:0] a_o, input logic [15:0] b_o);
    int exp_cnt;
    exp_cnt = (m_len > cmax) ? cmax : m_len;
    check_eq({pfx, "_ready"}, 32'(rdy_o), 32'(!m_holding));
    check_eq({pfx, "_valid"}, 32'(vld_o), 32'(m_holding));
    check_eq({pfx, "_sum"},   32'(sum_o), 32'(m_last_sum));
    check_eq({pfx, "_count"}, cnt_o, 32'(exp_cnt));
    check_eq({pfx, "_ovf"},   32'(ovf_o), 32'(m_len > cmax));
    check_eq({pfx, "_add_a"}, 32'(a_o), 32'(m_acc));
    check_eq({pfx, "_add_b"}, 32'(b_o), 32'(data));
  endtask

  // One clock: drive, check at negedge, advance model, step past the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r);
    logic [15:0] res;
    valid = v; data = d; last = l; rdy = r;
    @(negedge clk);
    check_dut("w8", 255, ready8, valid8, sum8, 32'(count8), ovf8, add_a8, add_b8);
    check_dut("w2", 3, ready2, valid2, sum2, 32'(count2), ovf2, add_a2, add_b2);
    if (m_holding) begin
      if (r) begin
        m_holding = 1'b0;
        m_acc = '0;
        m_len = 0;
      end
    end else if (v) begin
      res = fp16_add(m_acc, d);
      m_acc = res;
      m_len++;
      if (l) begin
        m_holding = 1'b1;
        m_last_sum = res;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_acc = '0; m_last_sum = '0; m_len = 0; m_holding = 1'b0;
    check_eq("rst_ready8", 32'(ready8), 32'd0);
    check_eq("rst_ready2", 32'(ready2), 32'd0);
    check_eq("rst_valid8", 32'(valid8), 32'd0);
    check_eq("rst_sum8",   32'(sum8), 32'd0);
    check_eq("rst_count8", 32'(count8), 32'd0);
    check_eq("rst_count2", 32'(count2), 32'd0);
    check_eq("rst_ovf2",   32'(ovf2), 32'd0);
    check_eq("rst_acc8",   32'(add_a8), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [15:0] pkt[$];

  // Send pkt with random input gaps, then hold the total for 'stall' cycles
  // while offering junk beats that must not be taken, then release it.
  task automatic run_pkt(input int stall, input bit gaps);
    for (int k = 0; k < pkt.size(); k++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++)
          step(1'b0, 16'($urandom), 1'($urandom), 1'($urandom));
      end
      step(1'b1, pkt[k], (k == pkt.size() - 1), 1'b1);
    end
    for (int s = 0; s < stall; s++)
      step(1'b1, 16'($urandom), 1'($urandom), 1'b0);
    step(1'b1, 16'($urandom), 1'b1, 1'b1);
    check_eq("released", 32'(m_holding), 32'd0);
  endtask

  function automatic logic [15:0] rand_fp16();
    logic [15:0] r;
    case ($urandom_range(0, 15))
      0: r = 16'h7E00;
      1: r = {1'($urandom), 15'h7C00};
      2: r = {1'($urandom), 5'd0, 10'($urandom)};
      default: r = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
    endcase
    return r;
  endfunction

  initial begin
    #12;
    do_reset();

    pkt = '{16'h3C00, 16'h4000};
    run_pkt(0, 0);
    check_eq("dir_1p2", 32'(sum8), 32'h4200);

    pkt = '{16'h3800};
    run_pkt(0, 0);
    check_eq("dir_single", 32'(sum8), 32'h3800);

    // 1.0 + 1.5 = 2.5 exactly.
    pkt = '{16'h3C00, 16'h3E00};
    run_pkt(5, 0);
    check_eq("dir_stall", 32'(sum8), 32'h4100);

    pkt = '{16'h4000};
    run_pkt(0, 0);
    check_eq("dir_after_stall", 32'(sum8), 32'h4000);

    pkt = '{16'h7C00, 16'hFC00};
    run_pkt(0, 0);
    check_eq("dir_inf", 32'(sum8), 32'h0000);

    pkt = '{16'h7E00, 16'h3C00};
    run_pkt(0, 0);
    check_eq("dir_nan", 32'(sum8), 32'h7C77);

    pkt = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    run_pkt(1, 0);
    check_eq("dir_five8", 32'(sum8), 32'h4500);
    check_eq("dir_five2", 32'(sum2), 32'h4500);

    pkt = '{16'h3C00};
    run_pkt(0, 0);

    step(1'b1, 16'h4000, 1'b0, 1'b1);
    step(1'b1, 16'h4000, 1'b0, 1'b1);
    do_reset();
    pkt = '{16'h3800, 16'h3800};
    run_pkt(0, 0);
    check_eq("dir_post_rst", 32'(sum8), 32'h3C00);

    // Long packet: exercises CNT_W=8 saturation and overflow.
    pkt.delete();
    for (int k = 0; k < 260; k++) pkt.push_back((k % 2 == 0) ? 16'h3C00 : 16'hBC00);
    run_pkt(2, 0);

    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) pkt.push_back(rand_fp16());
      run_pkt(int'($urandom_range(0, 3)), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
